// File: rtl/mask_rand_pkg.sv
// Shared constants and FSM encoding for the masked-S-box randomness feed.
package mask_rand_pkg;

  localparam int STATE_W_DEF = 128;
  localparam int SEED_WORDS  = STATE_W_DEF / 32;

  // x^128 + x^126 + x^101 + x^99 + 1
  localparam logic [127:0] TAP_MASK = (128'h1 << 127) | (128'h1 << 125) |
                                      (128'h1 << 100) | (128'h1 << 98);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational N-step unroll of a left-shifting Fibonacci LFSR.
module lfsr_step_n #(
  parameter int                 N       = 1,
  parameter int                 STATE_W = 128,
  parameter logic [STATE_W-1:0] TAPS    = '0
) (
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_state
);

  always_comb begin
    o_state = i_state;
    for (int k = 0; k < N; k++) begin
      o_state = {o_state[STATE_W-2:0], ^(o_state & TAPS)};
    end
  end

endmodule

// File: rtl/mask_rand_feed.sv
// Seeded LFSR randomness source: one RAND_W-bit word per handshake, no bubbles under full-rate ready.
// Optional reseed request counter enabled by defining MASK_RAND_RESEED_EN.
module mask_rand_feed
  import mask_rand_pkg::*;
#(
  parameter int RAND_W     = 90,
  parameter int STATE_W    = STATE_W_DEF,
  parameter int WARMUP_CYC = 16
`ifdef MASK_RAND_RESEED_EN
  , parameter int RESEED_INT = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       seed_word,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic [RAND_W-1:0] rand_out,
  output logic              rand_valid,
  input  logic              rand_ready
`ifdef MASK_RAND_RESEED_EN
  , output logic            reseed_req
`endif
);

  localparam int SEED_N = STATE_W / 32;
  localparam int SCW    = $clog2(SEED_N + 1);
  localparam int WCW    = $clog2(WARMUP_CYC + 1);
  localparam logic [STATE_W-1:0] TAPS = STATE_W'(TAP_MASK);

  state_e             r_fsm, w_fsm_nxt;
  logic [STATE_W-1:0] r_state, w_state_nxt, w_step1, w_stepn, w_shift;
  logic [SCW-1:0]     r_seed_cnt, w_seed_cnt_nxt;
  logic [WCW-1:0]     r_warm_cnt, w_warm_cnt_nxt;
  logic               w_seed_acc, w_rand_xfer;

  lfsr_step_n #(.N(1), .STATE_W(STATE_W), .TAPS(TAPS)) u_step1 (
    .i_state (r_state),
    .o_state (w_step1)
  );

  lfsr_step_n #(.N(RAND_W), .STATE_W(STATE_W), .TAPS(TAPS)) u_stepn (
    .i_state (r_state),
    .o_state (w_stepn)
  );

  generate
    if (STATE_W > 32) begin : g_shift_wide
      assign w_shift = {r_state[STATE_W-33:0], seed_word};
    end else begin : g_shift_word
      assign w_shift = seed_word;
    end
  endgenerate

  assign seed_ready  = (r_fsm != WARMUP);
  assign rand_valid  = (r_fsm == RUN);
  assign rand_out    = rand_valid ? r_state[RAND_W-1:0] : '0;
  assign w_seed_acc  = seed_valid && seed_ready;
  assign w_rand_xfer = rand_valid && rand_ready;

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_state_nxt    = r_state;
    w_seed_cnt_nxt = r_seed_cnt;
    w_warm_cnt_nxt = r_warm_cnt;
    unique case (r_fsm)
      WARMUP: begin
        w_state_nxt = w_step1;
        if (r_warm_cnt == WCW'(WARMUP_CYC - 1)) begin
          w_fsm_nxt      = RUN;
          w_warm_cnt_nxt = '0;
        end else begin
          w_warm_cnt_nxt = r_warm_cnt + WCW'(1);
        end
      end
      RUN: begin
        if (w_rand_xfer) w_state_nxt = w_stepn;
      end
      default: begin
      end
    endcase
    // A seed word accepted in RUN overwrites any same-cycle advance.
    if (w_seed_acc) begin
      w_state_nxt = w_shift;
      if (r_seed_cnt == SCW'(SEED_N - 1)) begin
        if (w_shift == '0) w_state_nxt = STATE_W'(1);
        w_fsm_nxt      = WARMUP;
        w_seed_cnt_nxt = '0;
      end else begin
        w_fsm_nxt      = SEED;
        w_seed_cnt_nxt = r_seed_cnt + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= SEED;
      r_state    <= '0;
      r_seed_cnt <= '0;
      r_warm_cnt <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_state    <= w_state_nxt;
      r_seed_cnt <= w_seed_cnt_nxt;
      r_warm_cnt <= w_warm_cnt_nxt;
    end
  end

`ifdef MASK_RAND_RESEED_EN
  localparam int RCW = $clog2(RESEED_INT + 1);

  logic [RCW-1:0] r_word_cnt;
  logic           r_reseed;

  // Counter parks at RESEED_INT while the request is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_reseed   <= 1'b0;
    end else if (w_seed_acc && (r_seed_cnt == '0)) begin
      r_word_cnt <= '0;
      r_reseed   <= 1'b0;
    end else if (w_rand_xfer && !r_reseed) begin
      r_word_cnt <= r_word_cnt + RCW'(1);
      if (r_word_cnt == RCW'(RESEED_INT - 1)) r_reseed <= 1'b1;
    end
  end

  assign reseed_req = r_reseed;
`endif

endmodule

// File: tb/tb_mask_rand_feed.sv
// Directed bench for mask_rand_feed against an independent LFSR reference.
module tb_mask_rand_feed;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed_word;
  logic        seed_valid;
  logic        seed_ready;
  logic [89:0] rand_out;
  logic        rand_valid;
  logic        rand_ready;
`ifdef MASK_RAND_RESEED_EN
  logic        reseed_req;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] m;

  always #5 clk = ~clk;

`ifdef MASK_RAND_RESEED_EN
  mask_rand_feed #(.RESEED_INT(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .seed_word  (seed_word),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .reseed_req (reseed_req)
  );
`else
  mask_rand_feed u_dut (
    .clk        (clk),
    .rst        (rst),
    .seed_word  (seed_word),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready)
  );
`endif

  typedef struct packed {
    logic [127:0] w;
    logic [127:0] exp_seed;
    logic [127:0] first;
    logic         has_first;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [127:0] adv(input logic [127:0] s, input int n);
    logic [127:0] t = s;
    for (int k = 0; k < n; k++) t = {t[126:0], t[127] ^ t[125] ^ t[100] ^ t[98]};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last word's edge.
  task automatic do_seed(input logic [127:0] w);
    for (int i = 0; i < 4; i++) begin
      seed_word  = w[127-32*i -: 32];
      seed_valid = 1'b1;
      chk("seed_ready", 128'(seed_ready), 128'(1));
      if (i > 0) chk("valid_in_seed", 128'(rand_valid), 128'(0));
      @(posedge clk);
      @(negedge clk);
    end
    seed_valid = 1'b0;
  endtask

  task automatic wait_run();
    int  cnt = 0;
    bit  rdy_seen = 1'b0;
    bit  out_seen = 1'b0;
    while (!rand_valid && cnt < 64) begin
      if (seed_ready) rdy_seen = 1'b1;
      if (rand_out != '0) out_seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk("warmup_len", 128'(cnt), 128'(16));
    chk("warmup_seed_ready", 128'(rdy_seen), 128'(0));
    chk("warmup_out_zero", 128'(out_seen), 128'(0));
  endtask

  task automatic stream(input int n);
    logic [89:0] prev = '0;
    bit          have_prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("stream_valid", 128'(rand_valid), 128'(1));
      chk("stream_word", 128'(rand_out), 128'(m[89:0]));
      if (rand_ready) begin
        if (have_prev) chk("stream_distinct", 128'(rand_out == prev), 128'(0));
        prev      = rand_out;
        have_prev = 1'b1;
        m         = adv(m, 90);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{w: 128'h1, exp_seed: 128'h1, first: 128'h10000, has_first: 1'b1};
    vecs[1] = '{w: 128'h0, exp_seed: 128'h1, first: 128'h10000, has_first: 1'b1};
    vecs[2] = '{w: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                exp_seed: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                first: '0, has_first: 1'b0};
    vecs[3] = '{w: {128{1'b1}}, exp_seed: {128{1'b1}}, first: '0, has_first: 1'b0};

    rst        = 1'b1;
    seed_word  = '0;
    seed_valid = 1'b0;
    rand_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", 128'(rand_valid), 128'(0));
    chk("rst_seed_ready", 128'(seed_ready), 128'(1));
    chk("rst_out", 128'(rand_out), 128'(0));
`ifdef MASK_RAND_RESEED_EN
    chk("rst_reseed", 128'(reseed_req), 128'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      m = vecs[v].exp_seed;
      do_seed(vecs[v].w);
      wait_run();
      m = adv(m, 16);
      if (vecs[v].has_first) chk("hand_first", 128'(rand_out), vecs[v].first);
      rand_ready = 1'b1;
      stream(8);
      rand_ready = 1'b0;
    end

    // Hold, then full-rate drain.
    @(negedge clk);
    stream(10);
    rand_ready = 1'b1;
    stream(200);

    // Reseed while words are being taken.
    m = 128'hdead_beef_0bad_f00d_c0ff_ee00_1234_5678;
    do_seed(m);
    wait_run();
    m = adv(m, 16);
    stream(8);

    // Reset in the 8th warm-up cycle, then partial seed lost to a reset.
    rand_ready = 1'b0;
    do_seed(vecs[2].w);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 128'(rand_valid), 128'(0));
    chk("midrst_seed_ready", 128'(seed_ready), 128'(1));
    chk("midrst_out", 128'(rand_out), 128'(0));
    rst = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (rand_valid || !seed_ready) seen = 1'b1;
      end
      chk("idle_after_rst", 128'(seen), 128'(0));
    end
    seed_word  = 32'hAAAA_5555;
    seed_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    seed_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m = vecs[3].exp_seed;
    do_seed(vecs[3].w);
    wait_run();
    m = adv(m, 16);
    rand_ready = 1'b1;
    stream(4);

`ifdef MASK_RAND_RESEED_EN
    rand_ready = 1'b0;
    m = vecs[2].exp_seed;
    do_seed(vecs[2].w);
    wait_run();
    m = adv(m, 16);
    chk("reseed_clear", 128'(reseed_req), 128'(0));
    rand_ready = 1'b1;
    stream(3);
    chk("reseed_before", 128'(reseed_req), 128'(0));
    stream(1);
    chk("reseed_set", 128'(reseed_req), 128'(1));
    stream(2);
    chk("reseed_hold", 128'(reseed_req), 128'(1));
    seed_word  = 32'h1;
    seed_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seed_valid = 1'b0;
    chk("reseed_first_word", 128'(reseed_req), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
